// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between WB (priority) and queued MUL/DIV results,
// forcing a drain after STARVE_LIMIT starved cycles. Optional macro: MD_BYPASS_EN (same-cycle MD write).
module rf_write_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wb_RegWrite,
  input  logic [4:0]            i_wb_Rd,
  input  logic [DATA_WIDTH-1:0] i_wb_Data,
  input  logic                  i_md_valid,
  output logic                  o_md_ready,
  input  logic [4:0]            i_md_Rd,
  input  logic [DATA_WIDTH-1:0] i_md_Data,
  output logic                  o_rf_RegWrite,
  output logic [4:0]            o_rf_Rd,
  output logic [DATA_WIDTH-1:0] o_rf_WriteData,
  output logic                  o_pipe_stall,
  output logic [31:0]           o_pend_mask,
  output logic                  o_dbg_state
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic {S_NORMAL = 1'b0, S_FORCE = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           count_q, count_d;
  logic [PW-1:0]           rd_ptr_q, wr_ptr_q;
  logic [SW-1:0]           starve_q, starve_d;
  logic [FIFO_DEPTH-1:0]   valid_q, valid_d;
  logic [4:0]              q_rd_q [FIFO_DEPTH];
  logic [4:0]              rd_d   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   q_data_q [FIFO_DEPTH];
  logic [31:0]             pend_q, mask_d;

  logic                    full, empty, wb_req, md_xfer;
  logic                    push, pop, bypass, stall;
  logic                    rf_we;
  logic [4:0]              rf_rd;
  logic [DATA_WIDTH-1:0]   rf_data;

  // MD handshake: a result transfers on a rising edge where i_md_valid and o_md_ready are both
  // high; ready depends only on registered occupancy and reset, never on i_md_valid.
  assign full       = (count_q == FULL_CNT);
  assign empty      = (count_q == '0);
  assign wb_req     = i_wb_RegWrite && (i_wb_Rd != 5'd0);
  assign o_md_ready = !full && !i_rst;
  assign md_xfer    = i_md_valid && o_md_ready && (i_md_Rd != 5'd0);

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    rf_we   = 1'b0;
    rf_rd   = '0;
    rf_data = '0;
    pop     = 1'b0;
    bypass  = 1'b0;
    case (state_q)
      S_FORCE: begin
        stall   = 1'b1;
        state_d = S_NORMAL;
        if (!empty) begin
          rf_we   = 1'b1;
          rf_rd   = q_rd_q[rd_ptr_q];
          rf_data = q_data_q[rd_ptr_q];
          pop     = 1'b1;
        end
      end
      default: begin
        if (wb_req) begin
          rf_we   = 1'b1;
          rf_rd   = i_wb_Rd;
          rf_data = i_wb_Data;
        end else if (!empty) begin
          rf_we   = 1'b1;
          rf_rd   = q_rd_q[rd_ptr_q];
          rf_data = q_data_q[rd_ptr_q];
          pop     = 1'b1;
`ifdef MD_BYPASS_EN
        end else if (md_xfer) begin
          rf_we   = 1'b1;
          rf_rd   = i_md_Rd;
          rf_data = i_md_Data;
          bypass  = 1'b1;
`endif
        end
      end
    endcase

    push = md_xfer && !bypass;

    // A result counts as starved from the cycle it is enqueued while WB holds the port.
    if (pop)
      starve_d = '0;
    else if (wb_req && (!empty || push))
      starve_d = starve_q + 1'b1;
    else
      starve_d = '0;
    if (state_q == S_NORMAL && starve_d == STARVE_MAX)
      state_d = S_FORCE;

    valid_d = valid_q;
    rd_d    = q_rd_q;
    if (pop)
      valid_d[rd_ptr_q] = 1'b0;
    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      rd_d[wr_ptr_q]    = i_md_Rd;
    end
    mask_d = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (valid_d[i]) mask_d[rd_d[i]] = 1'b1;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_NORMAL;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      starve_q <= '0;
      valid_q  <= '0;
      pend_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) q_rd_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_q + PW'(pop);
      wr_ptr_q <= wr_ptr_q + PW'(push);
      starve_q <= starve_d;
      valid_q  <= valid_d;
      pend_q   <= mask_d;
      q_rd_q   <= rd_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && push)
      q_data_q[wr_ptr_q] <= i_md_Data;
  end

  assign o_rf_RegWrite  = rf_we && !i_rst;
  assign o_rf_Rd        = rf_rd;
  assign o_rf_WriteData = rf_data;
  assign o_pipe_stall   = stall;
  assign o_pend_mask    = pend_q;
  assign o_dbg_state    = (state_q == S_FORCE);

endmodule
